ram_banked_ctrl: RTL
====================

// Module: ram_banked_ctrl
// PURPOSE
//  Parametrised data memory with byte-enable writes, req/ready/ack handshake and
//  programmable access latency (wait states). Next-generation data/instruction RAM
//  for multicycle/pipelined CPUs; models slow memory and flags bad accesses.
// PARAMETERS
//  DATA_W      32    data width in bits; multiple of 8; NB = DATA_W/8 byte lanes
//  DEPTH       1024  number of words; power of 2
//  ADDR_W      32    byte-address width
//  WAIT_CYCLES 2     extra cycles between accept and ack; 0..15
// PORTS
//  clk    in   1       clock, rising edge
//  rst_n  in   1       asynchronous active-low reset
//  req    in   1       access request
//  we     in   1       1 = write, 0 = read; sampled with req
//  addr   in   ADDR_W  byte address; word index = addr >> log2(NB)
//  wdata  in   DATA_W  write data
//  be     in   NB      byte enables; bit i controls wdata[8i+7:8i]
//  ready  out  1       block can accept a request this cycle
//  ack    out  1       one-cycle completion pulse
//  rdata  out  DATA_W  read data; valid only while ack=1 for a read
//  err    out  1       access fault; valid only while ack=1
// BEHAVIOUR
//  - Reset (rst_n=0, async): state IDLE, wait counter 0, ready=1, ack=0,
//    rdata=0, err=0. Memory array NOT reset. Reset mid-access abandons it; a
//    pending write does not modify memory.
//  - FSM: IDLE -> (req&ready) -> WAIT (WAIT_CYCLES>0) or DONE (WAIT_CYCLES=0);
//    WAIT counts WAIT_CYCLES cycles -> DONE; DONE lasts exactly 1 cycle -> IDLE,
//    or -> WAIT/DONE again if a new request is accepted in DONE.
//  - ready=1 in IDLE and DONE, 0 in WAIT. Accept = req&ready at a rising edge;
//    we/addr/wdata/be are latched at accept; later input changes are ignored.
//  - Latency: accept at edge k -> ack high from edge k+WAIT_CYCLES+1 for one
//    cycle. Back-to-back: accepting in DONE gives a throughput of one access per
//    WAIT_CYCLES+1 cycles (1/cycle at WAIT_CYCLES=0).
//  - Write commit: at the edge entering DONE, each lane with be[i]=1 is written;
//    lanes with be[i]=0 are unchanged. be=0 is a legal no-op write (ack, err=0).
//  - Read: rdata = word at the edge entering DONE; includes any write committed at
//    an earlier edge (read-after-write returns new data). rdata=0 when not in DONE.
//  - err=1 with ack if addr low log2(NB) bits != 0 (misaligned) or word index
//    >= DEPTH (out of range). On err: no write occurs; rdata=0.
//  - Address wrap is not performed; upper bits beyond log2(DEPTH) are checked, not
//    truncated.
//  - req while ready=0 is ignored (not queued); the master must hold req.
// TESTING
//  1 Reset: rst_n=0 -> ready=1, ack=0, err=0, rdata=0; release -> still IDLE.
//  2 WAIT_CYCLES=2: write addr=0x10, wdata=0xDEADBEEF, be=4'hF at edge k ->
//    ready=0 for 2 cycles, ack at edge k+3; read 0x10 -> rdata=0xDEADBEEF, err=0.
//  3 Byte enable: word 0x10=0xDEADBEEF, write wdata=0x11223344, be=4'b0101 ->
//    read 0x10 returns 0xDE22BE44.
//  4 Faults: read addr=0x13 -> ack with err=1, rdata=0; write addr=0x1000
//    (DEPTH=1024) -> err=1, word 0 unchanged on read back.
//  5 WAIT_CYCLES=0 back-to-back: req held 4 cycles (W 0x0=1, W 0x4=2, R 0x0,
//    R 0x4) -> ack every cycle, reads return 1 then 2.
//  6 Reset mid-write: accept write 0x20=0xCAFEF00D, rst_n low during WAIT ->
//    ack never asserted; later read 0x20 returns the prior contents.

Source files
------------

// File: rtl/ram_banked_ctrl.sv
// Word-addressed data RAM with byte enables, req/ready/ack handshake and a
// fixed number of wait states between accept and completion. Misaligned or
// out-of-range accesses complete with err=1 and have no side effect.
module ram_banked_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      wdata,
  input  logic [DATA_W/8-1:0]    be,
  output logic                   ready,
  output logic                   ack,
  output logic [DATA_W-1:0]      rdata,
  output logic                   err
);

  localparam int unsigned NB       = DATA_W / 8;
  localparam int unsigned LB       = $clog2(NB);
  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_ready;
  logic              r_ack;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;

  logic              r_lat_we;
  logic              r_lat_err;
  logic [IDX_W-1:0]  r_lat_idx;
  logic [DATA_W-1:0] r_lat_wdata;
  logic [NB-1:0]     r_lat_be;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_accept;
  logic [ADDR_W-1:0] w_live_word;
  logic              w_live_err;
  logic [IDX_W-1:0]  w_live_idx;
  logic              w_use_lat;
  logic              w_we;
  logic              w_err;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_wdata;
  logic [NB-1:0]     w_be;
  logic              w_done_nxt;
  logic              w_commit;

  // Decode the live request: word index, alignment and range fault.
  assign w_accept    = req && r_ready;
  assign w_live_word = addr >> LB;
  assign w_live_err  = ((addr & ADDR_W'(NB - 1)) != '0) ||
                       (w_live_word >= ADDR_W'(DEPTH));
  assign w_live_idx  = w_live_word[IDX_W-1:0];

  // The access completing now was latched earlier unless it skips WAIT.
  assign w_use_lat  = (r_state == S_WAIT);
  assign w_we       = w_use_lat ? r_lat_we    : we;
  assign w_err      = w_use_lat ? r_lat_err   : w_live_err;
  assign w_idx      = w_use_lat ? r_lat_idx   : w_live_idx;
  assign w_wdata    = w_use_lat ? r_lat_wdata : wdata;
  assign w_be       = w_use_lat ? r_lat_be    : be;
  assign w_done_nxt = (w_state_nxt == S_DONE);
  assign w_commit   = rst_n && w_done_nxt && w_we && !w_err;

  // State and wait counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: accept in IDLE/DONE, count wait states, one-cycle DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (r_state == S_DONE) w_state_nxt = S_IDLE;
        if (w_accept) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Capture request fields at accept so later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat_we    <= 1'b0;
      r_lat_err   <= 1'b0;
      r_lat_idx   <= '0;
      r_lat_wdata <= '0;
      r_lat_be    <= '0;
    end else if (w_accept) begin
      r_lat_we    <= we;
      r_lat_err   <= w_live_err;
      r_lat_idx   <= w_live_idx;
      r_lat_wdata <= wdata;
      r_lat_be    <= be;
    end
  end

  // Registered handshake and read data, valid for the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b1;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= (w_state_nxt != S_WAIT);
      r_ack   <= w_done_nxt;
      r_err   <= w_done_nxt && w_err;
      r_rdata <= (w_done_nxt && !w_we && !w_err) ? r_mem[w_idx] : '0;
    end
  end

  // Byte-lane write commit on the edge entering DONE; array is not reset.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  assign ready = r_ready;
  assign ack   = r_ack;
  assign err   = r_err;
  assign rdata = r_rdata;

endmodule
